// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port memory.
// ADDR_W/DATA_W must match the parameters given to mem_arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    // requester side
    logic              req_a, req_b;
    logic              we_a, we_b;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [DATA_W-1:0] wdata_a, wdata_b;
    logic              gnt_a, gnt_b;
    logic              rvalid_a, rvalid_b;
    logic [DATA_W-1:0] rdata_a, rdata_b;
    logic              prio_mode;

    // memory side
    logic              wr_enable;
    logic [ADDR_W-1:0] write_addr, read_addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_out;

    // status
    logic              busy;
    logic [15:0]       cnt_a, cnt_b;

    // arbiter view
    modport slave (
        input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, prio_mode, read_out,
        output gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b,
               wr_enable, write_addr, read_addr, write_data, busy, cnt_a, cnt_b
    );

    // requester + memory environment view
    modport master (
        output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, prio_mode, read_out,
        input  gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b,
               wr_enable, write_addr, read_addr, write_data, busy, cnt_a, cnt_b
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port memory with a 1-cycle read.
// Pipeline: accept (comb grant) -> command register -> response (read data).

// Per-requester slice: saturating grant counter and read-response gating.
module mem_arbiter_lane #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              gnt_i,
    input  logic              rsp_hit_i,
    input  logic [DATA_W-1:0] read_out_i,
    output logic              rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [15:0]       cnt_o
);
    logic [15:0] cnt_q, cnt_d;

    // count grants, sticking at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (gnt_i && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
    end

    // counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign rvalid_o = rsp_hit_i;
    assign rdata_o  = rsp_hit_i ? read_out_i : '0;
    assign cnt_o    = cnt_q;
endmodule

module mem_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.slave bus
);
    localparam int NUM_LANES = 2;

    typedef enum logic {OWN_A = 1'b0, OWN_B = 1'b1} owner_e;

    typedef struct packed {
        logic              we;
        owner_e            own;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    logic [NUM_LANES-1:0]             req, gnt, we, rsp_hit, rvalid;
    logic [NUM_LANES-1:0][ADDR_W-1:0] addr;
    logic [NUM_LANES-1:0][DATA_W-1:0] wdata, rdata;
    logic [NUM_LANES-1:0][15:0]       cnt;

    owner_e last_q, last_d;
    logic   cmd_vld_q, cmd_vld_d;
    cmd_t   cmd_q, cmd_d;
    logic   rsp_vld_q, rsp_vld_d;
    owner_e rsp_own_q, rsp_own_d;

    assign req   = {bus.req_b,   bus.req_a};
    assign we    = {bus.we_b,    bus.we_a};
    assign addr  = {bus.addr_b,  bus.addr_a};
    assign wdata = {bus.wdata_b, bus.wdata_a};

    // grant: lone requester wins at once; on a tie fixed mode favours A,
    // round-robin favours whoever did not win last. Nothing is granted in reset.
    always_comb begin
        gnt    = '0;
        gnt[0] = rst_n && req[0] && (!req[1] || bus.prio_mode || (last_q == OWN_B));
        gnt[1] = rst_n && req[1] && !gnt[0];
    end

    // next state of pointer and command/response stages
    always_comb begin
        last_d    = last_q;
        cmd_vld_d = |gnt;
        cmd_d     = cmd_q;
        rsp_vld_d = cmd_vld_q && !cmd_q.we;
        rsp_own_d = cmd_q.own;
        if (gnt[1]) begin
            last_d = OWN_B;
            cmd_d  = '{we: we[1], own: OWN_B, addr: addr[1], wdata: wdata[1]};
        end else if (gnt[0]) begin
            last_d = OWN_A;
            cmd_d  = '{we: we[0], own: OWN_A, addr: addr[0], wdata: wdata[0]};
        end
    end

    // pipeline registers; reset drops everything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q    <= OWN_B;
            cmd_vld_q <= 1'b0;
            cmd_q     <= '{we: 1'b0, own: OWN_A, addr: '0, wdata: '0};
            rsp_vld_q <= 1'b0;
            rsp_own_q <= OWN_A;
        end else begin
            last_q    <= last_d;
            cmd_vld_q <= cmd_vld_d;
            cmd_q     <= cmd_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_own_q <= rsp_own_d;
        end
    end

    // route the returning read to its owner
    always_comb begin
        rsp_hit    = '0;
        rsp_hit[0] = rsp_vld_q && (rsp_own_q == OWN_A);
        rsp_hit[1] = rsp_vld_q && (rsp_own_q == OWN_B);
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        mem_arbiter_lane #(.DATA_W(DATA_W)) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .gnt_i      (gnt[g]),
            .rsp_hit_i  (rsp_hit[g]),
            .read_out_i (bus.read_out),
            .rvalid_o   (rvalid[g]),
            .rdata_o    (rdata[g]),
            .cnt_o      (cnt[g])
        );
    end

    assign bus.gnt_a      = gnt[0];
    assign bus.gnt_b      = gnt[1];
    assign bus.rvalid_a   = rvalid[0];
    assign bus.rvalid_b   = rvalid[1];
    assign bus.rdata_a    = rdata[0];
    assign bus.rdata_b    = rdata[1];
    assign bus.cnt_a      = cnt[0];
    assign bus.cnt_b      = cnt[1];
    assign bus.wr_enable  = cmd_vld_q && cmd_q.we;
    assign bus.write_addr = cmd_q.addr;
    assign bus.read_addr  = cmd_q.addr;
    assign bus.write_data = cmd_q.wdata;
    assign bus.busy       = cmd_vld_q || rsp_vld_q;
endmodule
